// File: rtl/e203_ifu_jalr_seq_pkg.sv
// Shared widths and JALR sequencer state encoding for the IFU.
package e203_ifu_jalr_seq_pkg;
  localparam int E203_XLEN        = 32;
  localparam int E203_PC_SIZE     = 32;
  localparam int E203_RFIDX_WIDTH = 5;

  localparam int E203_JSEQ_STATE_W = 3;
  typedef enum logic [E203_JSEQ_STATE_W-1:0] {
    E203_JSEQ_IDLE    = 3'd0,
    E203_JSEQ_WAIT_X1 = 3'd1,
    E203_JSEQ_WAIT_XN = 3'd2,
    E203_JSEQ_RD_XN   = 3'd3,
    E203_JSEQ_DONE_XN = 3'd4
  } e203_jseq_state_e;
endpackage

// File: rtl/e203_ifu_jalr_seq_if.sv
// Mini-decode fields in, static prediction and fetch stall out.
interface e203_ifu_jalr_seq_if
  import e203_ifu_jalr_seq_pkg::*;
#(
  parameter int XLEN    = E203_XLEN,
  parameter int PC_W    = E203_PC_SIZE,
  parameter int RFIDX_W = E203_RFIDX_WIDTH
);
  logic               dec_valid;
  logic               dec_jal;
  logic               dec_jalr;
  logic               dec_bxx;
  logic [RFIDX_W-1:0] dec_jalr_rs1idx;
  logic [XLEN-1:0]    dec_bjp_imm;
  logic [PC_W-1:0]    pc;
  logic               seq_wait;
  logic               prdt_taken;
  logic [PC_W-1:0]    prdt_op1;
  logic [PC_W-1:0]    prdt_op2;

  modport master (
    output dec_valid, dec_jal, dec_jalr, dec_bxx, dec_jalr_rs1idx, dec_bjp_imm, pc,
    input  seq_wait, prdt_taken, prdt_op1, prdt_op2
  );
  modport slave (
    input  dec_valid, dec_jal, dec_jalr, dec_bxx, dec_jalr_rs1idx, dec_bjp_imm, pc,
    output seq_wait, prdt_taken, prdt_op1, prdt_op2
  );
endinterface

// File: rtl/e203_ifu_jalr_dep_chk.sv
// JALR rs1 hazard detection: x1 write pending, or IR rs1 port/rd conflict for xn.
module e203_ifu_jalr_dep_chk
  import e203_ifu_jalr_seq_pkg::*;
#(
  parameter int RFIDX_W = E203_RFIDX_WIDTH
) (
  input  logic               oitf_empty,
  input  logic               ir_empty,
  input  logic               ir_rs1en,
  input  logic               ir_rdwen,
  input  logic [RFIDX_W-1:0] ir_rdidx,
  input  logic               ir_valid_clr,
  input  logic [RFIDX_W-1:0] rs1idx,
  output logic               x1_dep,
  output logic               xn_busy
);
  assign x1_dep  = !oitf_empty | (!ir_empty & ir_rdwen & (ir_rdidx == RFIDX_W'(1)));
  // An IR instruction retiring this cycle releases the shared read port.
  assign xn_busy = !oitf_empty
                 | ((!ir_empty & (ir_rs1en | (ir_rdwen & (ir_rdidx == rs1idx)))) & !ir_valid_clr);
endmodule

// File: rtl/e203_ifu_jalr_seq.sv
// IFU static branch prediction plus JALR rs1 fetch sequencing.
module e203_ifu_jalr_seq
  import e203_ifu_jalr_seq_pkg::*;
#(
  parameter int XLEN    = E203_XLEN,
  parameter int PC_W    = E203_PC_SIZE,
  parameter int RFIDX_W = E203_RFIDX_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  e203_ifu_jalr_seq_if.slave        dec,
  input  logic                      oitf_empty,
  input  logic                      ir_empty,
  input  logic                      ir_rs1en,
  input  logic                      ir_rdwen,
  input  logic [RFIDX_W-1:0]        ir_rdidx,
  input  logic                      ir_valid_clr,
  input  logic [XLEN-1:0]           rf2seq_x1,
  input  logic [XLEN-1:0]           rf2seq_rs1,
  input  logic                      flush,
  output logic                      seq2rf_rs1_ena
);
  e203_jseq_state_e state;
  logic [XLEN-1:0]  rs1_q;
  logic             x1_dep, xn_busy;

  e203_ifu_jalr_dep_chk #(.RFIDX_W(RFIDX_W)) u_dep_chk (
    .oitf_empty   (oitf_empty),
    .ir_empty     (ir_empty),
    .ir_rs1en     (ir_rs1en),
    .ir_rdwen     (ir_rdwen),
    .ir_rdidx     (ir_rdidx),
    .ir_valid_clr (ir_valid_clr),
    .rs1idx       (dec.dec_jalr_rs1idx),
    .x1_dep       (x1_dep),
    .xn_busy      (xn_busy)
  );

  logic is_jalr, rs1_x0, rs1_x1, rs1_xn, idle_leave;
  assign is_jalr    = dec.dec_valid & dec.dec_jalr;
  assign rs1_x0     = (dec.dec_jalr_rs1idx == RFIDX_W'(0));
  assign rs1_x1     = (dec.dec_jalr_rs1idx == RFIDX_W'(1));
  assign rs1_xn     = !rs1_x0 & !rs1_x1;
  assign idle_leave = is_jalr & ((rs1_x1 & x1_dep) | rs1_xn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= E203_JSEQ_IDLE;
      rs1_q <= '0;
    end else if (flush) begin
      state <= E203_JSEQ_IDLE;
    end else begin
      case (state)
        E203_JSEQ_IDLE:
          if (idle_leave)
            state <= rs1_x1  ? E203_JSEQ_WAIT_X1 :
                     xn_busy ? E203_JSEQ_WAIT_XN : E203_JSEQ_RD_XN;
        E203_JSEQ_WAIT_X1: if (!x1_dep)  state <= E203_JSEQ_IDLE;
        E203_JSEQ_WAIT_XN: if (!xn_busy) state <= E203_JSEQ_RD_XN;
        E203_JSEQ_RD_XN:   state <= E203_JSEQ_DONE_XN;
        E203_JSEQ_DONE_XN: begin
          rs1_q <= rf2seq_rs1;
          state <= E203_JSEQ_IDLE;
        end
        default: state <= E203_JSEQ_IDLE;
      endcase
    end
  end

  assign seq2rf_rs1_ena = (state == E203_JSEQ_RD_XN);

  logic            wait_c, taken_c;
  logic [PC_W-1:0] op1_c;

  always_comb begin
    wait_c = 1'b0;
    case (state)
      E203_JSEQ_IDLE:    wait_c = idle_leave & !flush;
      E203_JSEQ_WAIT_X1: wait_c = x1_dep;
      E203_JSEQ_WAIT_XN,
      E203_JSEQ_RD_XN:   wait_c = 1'b1;
      default:           wait_c = 1'b0;
    endcase
  end

  assign taken_c = dec.dec_valid
                 & (dec.dec_jal | dec.dec_jalr | (dec.dec_bxx & dec.dec_bjp_imm[XLEN-1]));

  // Regfile data arrives in DONE_XN; forward it so op1 is usable the same cycle wait drops.
  always_comb begin
    op1_c = dec.pc;
    if (is_jalr) begin
      if (rs1_x0)                          op1_c = '0;
      else if (rs1_x1)                     op1_c = PC_W'(rf2seq_x1);
      else if (state == E203_JSEQ_DONE_XN) op1_c = PC_W'(rf2seq_rs1);
      else                                 op1_c = PC_W'(rs1_q);
    end
  end

  // Prediction outputs read as zero while reset is held, even with live decode inputs.
  assign dec.seq_wait   = rst_n & wait_c;
  assign dec.prdt_taken = rst_n & taken_c;
  assign dec.prdt_op1   = rst_n ? op1_c : '0;
  assign dec.prdt_op2   = rst_n ? PC_W'(dec.dec_bjp_imm) : '0;
endmodule

// File: tb/tb_e203_ifu_jalr_seq.sv
// Directed bench for the IFU JALR sequencer.
module tb_e203_ifu_jalr_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        oitf_empty, ir_empty, ir_rs1en, ir_rdwen, ir_valid_clr, flush;
  logic [4:0]  ir_rdidx;
  logic [31:0] rf2seq_x1, rf2seq_rs1;
  logic        seq2rf_rs1_ena;
  int          checks = 0;
  int          errors = 0;
  int          ena_cnt;

  always #5 clk = ~clk;

  e203_ifu_jalr_seq_if dif ();

  e203_ifu_jalr_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dec            (dif),
    .oitf_empty     (oitf_empty),
    .ir_empty       (ir_empty),
    .ir_rs1en       (ir_rs1en),
    .ir_rdwen       (ir_rdwen),
    .ir_rdidx       (ir_rdidx),
    .ir_valid_clr   (ir_valid_clr),
    .rf2seq_x1      (rf2seq_x1),
    .rf2seq_rs1     (rf2seq_rs1),
    .flush          (flush),
    .seq2rf_rs1_ena (seq2rf_rs1_ena)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic dec_set(input logic v, input logic jal, input logic jalr, input logic bxx,
                         input logic [4:0] rs1, input logic [31:0] imm, input logic [31:0] pc);
    dif.dec_valid = v; dif.dec_jal = jal; dif.dec_jalr = jalr; dif.dec_bxx = bxx;
    dif.dec_jalr_rs1idx = rs1; dif.dec_bjp_imm = imm; dif.pc = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    dec_set(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
    oitf_empty = 1; ir_empty = 1; ir_rs1en = 0; ir_rdwen = 0; ir_rdidx = 0;
    ir_valid_clr = 0; flush = 0; rf2seq_x1 = 0; rf2seq_rs1 = 0;

    // reset state
    smp();
    chk("rst_wait",  {31'b0, dif.seq_wait},   32'd0);
    chk("rst_taken", {31'b0, dif.prdt_taken}, 32'd0);
    chk("rst_op1",   dif.prdt_op1,            32'd0);
    chk("rst_op2",   dif.prdt_op2,            32'd0);
    chk("rst_ena",   {31'b0, seq2rf_rs1_ena}, 32'd0);
    #2 rst_n = 1'b1;
    step();

    // JAL
    dec_set(1, 1, 0, 0, 5'd0, 32'h20, 32'h100);
    for (int c = 0; c < 2; c++) begin
      smp();
      chk($sformatf("jal_taken_c%0d", c), {31'b0, dif.prdt_taken}, 32'd1);
      chk($sformatf("jal_op1_c%0d", c),   dif.prdt_op1, 32'h100);
      chk($sformatf("jal_op2_c%0d", c),   dif.prdt_op2, 32'h20);
      chk($sformatf("jal_wait_c%0d", c),  {31'b0, dif.seq_wait}, 32'd0);
      step();
    end

    // BXX backward / forward
    dec_set(1, 0, 0, 1, 5'd0, 32'hFFFF_FFF0, 32'h140);
    smp();
    chk("bxx_bwd_taken", {31'b0, dif.prdt_taken}, 32'd1);
    chk("bxx_bwd_op1",   dif.prdt_op1, 32'h140);
    chk("bxx_bwd_wait",  {31'b0, dif.seq_wait}, 32'd0);
    step();
    dec_set(1, 0, 0, 1, 5'd0, 32'h10, 32'h144);
    smp();
    chk("bxx_fwd_taken", {31'b0, dif.prdt_taken}, 32'd0);
    chk("bxx_fwd_wait",  {31'b0, dif.seq_wait}, 32'd0);
    chk("bxx_fwd_ena",   {31'b0, seq2rf_rs1_ena}, 32'd0);
    step();

    // JALR x0
    dec_set(1, 0, 1, 0, 5'd0, 32'h8, 32'h180);
    smp();
    chk("jalr_x0_op1",   dif.prdt_op1, 32'h0);
    chk("jalr_x0_wait",  {31'b0, dif.seq_wait}, 32'd0);
    chk("jalr_x0_taken", {31'b0, dif.prdt_taken}, 32'd1);
    step();

    // JALR x1 with IR writing x1 for 3 cycles
    dec_set(1, 0, 1, 0, 5'd1, 32'h4, 32'h200);
    rf2seq_x1 = 32'h1234_5678;
    ir_empty = 0; ir_rdwen = 1; ir_rdidx = 5'd1;
    for (int c = 1; c <= 3; c++) begin
      smp();
      chk($sformatf("x1dep_wait_c%0d", c), {31'b0, dif.seq_wait}, 32'd1);
      step();
    end
    ir_empty = 1; ir_rdwen = 0; ir_rdidx = 0;
    smp();
    chk("x1dep_wait_clr", {31'b0, dif.seq_wait}, 32'd0);
    chk("x1dep_op1",      dif.prdt_op1, 32'h1234_5678);
    step();
    smp();
    chk("x1_idle_wait", {31'b0, dif.seq_wait}, 32'd0);
    step();

    // JALR x5, no hazard: minimum two wait cycles
    dec_set(1, 0, 1, 0, 5'd5, 32'h0, 32'h300);
    smp();
    chk("x5_c1_wait", {31'b0, dif.seq_wait}, 32'd1);
    chk("x5_c1_ena",  {31'b0, seq2rf_rs1_ena}, 32'd0);
    step();
    smp();
    chk("x5_c2_wait", {31'b0, dif.seq_wait}, 32'd1);
    chk("x5_c2_ena",  {31'b0, seq2rf_rs1_ena}, 32'd1);
    step();
    rf2seq_rs1 = 32'hDEAD_0000;
    smp();
    chk("x5_c3_wait", {31'b0, dif.seq_wait}, 32'd0);
    chk("x5_c3_ena",  {31'b0, seq2rf_rs1_ena}, 32'd0);
    chk("x5_c3_op1",  dif.prdt_op1, 32'hDEAD_0000);
    step();
    dif.dec_valid = 0;
    rf2seq_rs1 = 32'h0BAD_F00D;
    smp();
    chk("x5_after_wait", {31'b0, dif.seq_wait}, 32'd0);
    step();

    // JALR x9, flush while in RD_XN
    dec_set(1, 0, 1, 0, 5'd9, 32'h0, 32'h400);
    smp();
    chk("fl_c1_wait", {31'b0, dif.seq_wait}, 32'd1);
    chk("fl_c1_op1_held", dif.prdt_op1, 32'hDEAD_0000);
    step();
    flush = 1;
    smp();
    chk("fl_c2_ena", {31'b0, seq2rf_rs1_ena}, 32'd1);
    step();
    flush = 0; dif.dec_valid = 0;
    smp();
    chk("fl_c3_wait", {31'b0, dif.seq_wait}, 32'd0);
    chk("fl_c3_ena",  {31'b0, seq2rf_rs1_ena}, 32'd0);
    step();

    // JALR x7 with OITF busy for 4 cycles; flushed data must not be in rs1 reg
    dec_set(1, 0, 1, 0, 5'd7, 32'h0, 32'h500);
    oitf_empty = 0;
    ena_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) oitf_empty = 1;
      if (c == 7) rf2seq_rs1 = 32'h7777_0007;
      smp();
      if (c == 1) chk("x7_c1_op1_stale", dif.prdt_op1, 32'hDEAD_0000);
      chk($sformatf("x7_wait_c%0d", c), {31'b0, dif.seq_wait}, (c < 7) ? 32'd1 : 32'd0);
      chk($sformatf("x7_ena_c%0d", c), {31'b0, seq2rf_rs1_ena}, (c == 6) ? 32'd1 : 32'd0);
      if (seq2rf_rs1_ena) ena_cnt++;
      step();
    end
    chk("x7_ena_pulses", ena_cnt, 32'd1);
    dif.dec_valid = 0;
    step();

    // JALR x6 while IR holds an rs1 user that retires this same cycle
    dec_set(1, 0, 1, 0, 5'd6, 32'h0, 32'h600);
    ir_empty = 0; ir_rs1en = 1; ir_valid_clr = 1;
    smp();
    chk("clr_c1_wait", {31'b0, dif.seq_wait}, 32'd1);
    step();
    smp();
    chk("clr_c2_ena", {31'b0, seq2rf_rs1_ena}, 32'd1);
    step();
    dif.dec_valid = 0; ir_empty = 1; ir_rs1en = 0; ir_valid_clr = 0;
    step();

    // Async reset while in WAIT_X1
    dec_set(1, 0, 1, 0, 5'd1, 32'h44, 32'h700);
    rf2seq_x1 = 32'h5555_AAAA;
    ir_empty = 0; ir_rdwen = 1; ir_rdidx = 5'd1;
    step();
    smp();
    chk("rx_pre_wait", {31'b0, dif.seq_wait}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rx_wait",  {31'b0, dif.seq_wait},   32'd0);
    chk("rx_taken", {31'b0, dif.prdt_taken}, 32'd0);
    chk("rx_op1",   dif.prdt_op1,            32'd0);
    chk("rx_op2",   dif.prdt_op2,            32'd0);
    chk("rx_ena",   {31'b0, seq2rf_rs1_ena}, 32'd0);
    dif.dec_valid = 0; ir_empty = 1; ir_rdwen = 0;
    #2 rst_n = 1'b1;
    step();
    smp();
    chk("rx_after_wait", {31'b0, dif.seq_wait}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
